// File: rtl/pgm_ddram_arbiter.sv
// pgm_ddram_arbiter: N-channel 64-bit DDRAM read arbiter with ROM-loader pre-emption and read watchdog
module pgm_ddram_arbiter #(
  parameter int NCH = 4,
  parameter int AW = 29,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 255
) (
  input  logic              fixed_50m_clk,
  input  logic              reset_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*AW-1:0] addr,
  output logic [NCH-1:0]    ack,
  output logic              err,
  output logic [63:0]       rdata,
  output logic [2:0]        grant_ch,
  input  logic              ldr_en,
  input  logic              ldr_wr,
  input  logic [26:0]       ldr_addr,
  input  logic [15:0]       ldr_din,
  output logic              ldr_ready,
  output logic              ddram_rd,
  output logic              ddram_we,
  output logic [AW-1:0]     ddram_addr,
  output logic [63:0]       ddram_din,
  output logic [7:0]        ddram_be,
  input  logic [63:0]       ddram_dout,
  input  logic              ddram_busy,
  input  logic              ddram_dout_ready
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam int PW = $clog2(NCH);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, LOAD} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic err_q, err_d;
  logic [63:0] rdata_q, rdata_d;
  logic [2:0] grant_q, grant_d, rr_q, rr_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] idx;
  logic found, timeout, load, unused_ok;
  assign load = state_q == LOAD;
  assign timeout = TIMEOUT > 0 && cnt_q == CW'(TIMEOUT - 1);
  assign unused_ok = ldr_addr[0];
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = RR_MODE != 0 ? PW'((int'(rr_q) + 1 + i) % NCH) : PW'(i);
      if (!found && req[idx]) begin
        win = 3'(idx);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    grant_d = grant_q;
    rr_d = rr_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    ack_d = '0;
    err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ldr_en) begin
          state_d = LOAD;
        end else if (found) begin
          grant_d = win;
          rr_d = win;
          addr_d = addr[int'(win)*AW +: AW];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!ddram_busy) begin
          state_d = WAIT;
          cnt_d = '0;
        end
      end
      WAIT: begin
        if (ddram_dout_ready || timeout) begin
          rdata_d = ddram_dout_ready ? ddram_dout : '1;
          ack_d = NCH'(1) << grant_q;
          err_d = !ddram_dout_ready;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      LOAD: state_d = ldr_en ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge fixed_50m_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      grant_q <= '0;
      rr_q <= 3'(NCH - 1);
      cnt_q <= '0;
      rdata_q <= '0;
      ack_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end
  assign ack = ack_q;
  assign err = err_q;
  assign rdata = rdata_q;
  assign grant_ch = grant_q;
  assign ddram_rd = state_q == ISSUE;
  assign ldr_ready = load && !ddram_busy;
  assign ddram_we = load && ldr_wr && !ddram_busy;
  assign ddram_addr = load ? AW'(ldr_addr[26:3]) : addr_q;
  assign ddram_din = load ? {4{ldr_din}} : '0;
  assign ddram_be = load ? 8'(8'h03 << {ldr_addr[2:1], 1'b0}) : 8'hFF;
endmodule
